condicionador_botoes: RTL

// Conditions the raw push-button inputs upstream of the memory-game top level; its output drives that block's botoes[3:0].

---
 rtl/condicionador_botoes.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: 2-FF synchroniser, press/release debounce and
// multi-button rejection, producing a one-hot (or zero) level and a press pulse.
module condicionador_botoes #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_in,
  output logic [N_BOTOES-1:0] botoes_out,
  output logic                pulso_jogada,
  output logic                multiplo,
  output logic [3:0]          db_estado
);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    FILTRA_PRESS = 3'd1,
    PRESSIONADO  = 3'd2,
    FILTRA_SOLTA = 3'd3,
    INVALIDO     = 3'd4
  } estado_t;

  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] sync1_q, sync2_q;
  estado_t             estado_q, estado_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_BOTOES-1:0] cand_q, cand_d;
  logic [N_BOTOES-1:0] out_q, out_d;
  logic                pulso_q, pulso_d;
  logic                mult_q, mult_d;
  logic [N_BOTOES-1:0] s;
  logic                cand_um_bit;

  assign s           = sync2_q;
  assign cand_um_bit = (cand_q != '0) && ((cand_q & (cand_q - N_BOTOES'(1))) == '0);

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    out_d    = out_q;
    pulso_d  = 1'b0;
    mult_d   = mult_q;
    case (estado_q)
      OCIOSO: begin
        out_d  = '0;
        mult_d = 1'b0;
        if (s != '0) begin
          cand_d   = s;
          cnt_d    = '0;
          estado_d = FILTRA_PRESS;
        end
      end
      FILTRA_PRESS: begin
        if (s == '0) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else if (s != cand_q) begin
          cand_d = s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_FIM) begin
          // cnt restarts so INVALIDO must see a full run of zeros to exit
          cnt_d = '0;
          if (cand_um_bit) begin
            estado_d = PRESSIONADO;
            out_d    = cand_q;
            pulso_d  = 1'b1;
          end else begin
            estado_d = INVALIDO;
            mult_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSIONADO: begin
        if (s != out_q) begin
          cnt_d    = '0;
          estado_d = FILTRA_SOLTA;
        end
      end
      FILTRA_SOLTA: begin
        if (s == out_q) begin
          cnt_d    = '0;
          estado_d = PRESSIONADO;
        end else if (s == '0) begin
          if (cnt_q == CNT_FIM) begin
            cnt_d    = '0;
            out_d    = '0;
            estado_d = OCIOSO;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      INVALIDO: begin
        out_d  = '0;
        mult_d = 1'b1;
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_FIM) begin
          cnt_d    = '0;
          mult_d   = 1'b0;
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
        cand_d   = '0;
        out_d    = '0;
        mult_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      cand_q   <= '0;
      out_q    <= '0;
      pulso_q  <= 1'b0;
      mult_q   <= 1'b0;
    end else begin
      sync1_q  <= botoes_in;
      sync2_q  <= sync1_q;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      out_q    <= out_d;
      pulso_q  <= pulso_d;
      mult_q   <= mult_d;
    end
  end

  assign botoes_out   = out_q;
  assign pulso_jogada = pulso_q;
  assign multiplo     = mult_q;
  assign db_estado    = {1'b0, estado_q};

endmodule
